// File: rtl/f4_pkg.sv
// rtl/f4_pkg.sv - class codes, FIFO depth and occupancy encoding shared by f4_stream and its consumers
package f4_pkg;

  localparam logic [1:0] CLS_NEG  = 2'd0;
  localparam logic [1:0] CLS_POS  = 2'd1;
  localparam logic [1:0] CLS_ZERO = 2'd2;

  localparam int FIFO_DEPTH = 3;

  // Occupancy state doubles as the FIFO entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } occ_t;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/f4_stream_if.sv
// rtl/f4_stream_if.sv - argument/result valid-ready handshake bundle for f4_stream
interface f4_stream_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/f4_classify.sv
// rtl/f4_classify.sv - combinational sign classifier, code zero-extended to DATA_W
module f4_classify
  import f4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] cls
);

  always_comb begin
    cls = DATA_W'(CLS_ZERO);
    if (data[DATA_W-1]) begin
      cls = DATA_W'(CLS_NEG);
    end else if (data != '0) begin
      cls = DATA_W'(CLS_POS);
    end
  end

endmodule

// File: rtl/f4_stream.sv
// rtl/f4_stream.sv - stage-1 register plus 3-entry class-code FIFO; F4_STREAM_STATS_EN adds saturating class counters
module f4_stream
  import f4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  f4_stream_if.slave       bus
`ifdef F4_STREAM_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_neg,
  output logic [CNT_W-1:0] cnt_pos,
  output logic [CNT_W-1:0] cnt_zero
`endif
);

  occ_t              state;
  occ_t              state_nxt;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s1_cls;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        fifo_count;
  logic              in_ready;
  logic              out_valid;
  logic              in_fire;
  logic              push;
  logic              pop;

  f4_classify #(.DATA_W(DATA_W)) u_classify (
    .data (s1_data),
    .cls  (s1_cls)
  );

  assign fifo_count = state;
  assign in_fire    = bus.in_valid && in_ready;
  assign push       = s1_valid;
  assign pop        = out_valid && bus.out_ready;

  // in_ready looks only at registered state (never out_ready) and is forced low while in reset.
  always_comb begin
    state_nxt = state;
    out_valid = (state != EMPTY);
    in_ready  = reset_n && (({1'b0, fifo_count} + {2'b00, s1_valid}) < 3'(FIFO_DEPTH));
    case ({push, pop})
      2'b10:   state_nxt = occ_t'(state + 2'd1);
      2'b01:   state_nxt = occ_t'(state - 2'd1);
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_data <= bus.in_data;
      end
      if (push) begin
        mem[wr_ptr] <= s1_cls;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem[rd_ptr];

`ifdef F4_STREAM_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_neg  <= '0;
      cnt_pos  <= '0;
      cnt_zero <= '0;
    end else if (stats_clr) begin
      cnt_neg  <= '0;
      cnt_pos  <= '0;
      cnt_zero <= '0;
    end else if (push) begin
      if (s1_cls == DATA_W'(CLS_NEG) && cnt_neg != '1) begin
        cnt_neg <= cnt_neg + 1'b1;
      end
      if (s1_cls == DATA_W'(CLS_POS) && cnt_pos != '1) begin
        cnt_pos <= cnt_pos + 1'b1;
      end
      if (s1_cls == DATA_W'(CLS_ZERO) && cnt_zero != '1) begin
        cnt_zero <= cnt_zero + 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_f4_stream.sv
// tb/tb_f4_stream.sv - directed self-checking bench for f4_stream (stats checks when F4_STREAM_STATS_EN is defined)
module tb_f4_stream;

  localparam int DATA_W = 8;
`ifdef F4_STREAM_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  f4_stream_if #(.DATA_W(DATA_W)) bus ();

`ifdef F4_STREAM_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] cnt_neg;
  logic [CNT_W-1:0] cnt_pos;
  logic [CNT_W-1:0] cnt_zero;
`endif

  f4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus)
`ifdef F4_STREAM_STATS_EN
    ,
    .stats_clr (stats_clr),
    .cnt_neg   (cnt_neg),
    .cnt_pos   (cnt_pos),
    .cnt_zero  (cnt_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] cls_of(input logic [7:0] d);
    if ($signed(d) < 0) return 8'd0;
    if (d == 8'd0) return 8'd2;
    return 8'd1;
  endfunction

  logic [7:0] dir_val [5];
  logic [7:0] dir_exp [5];
  logic [7:0] bp_val  [5];
  logic [7:0] bp_exp  [3];
  logic [7:0] exq[$];
  int         nres;
  int         acc;
  logic       hs;

  initial begin
    dir_val = '{8'hFB, 8'h07, 8'h00, 8'h80, 8'h7F};
    dir_exp = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
    bp_val  = '{8'h03, 8'hF0, 8'h00, 8'h11, 8'h22};
    bp_exp  = '{8'd1, 8'd0, 8'd2};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef F4_STREAM_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
`ifdef F4_STREAM_STATS_EN
    check("rst_cnt_neg", cnt_neg, 0);
    check("rst_cnt_pos", cnt_pos, 0);
    check("rst_cnt_zero", cnt_zero, 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    tick();
    check("rel_in_ready_edge", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);

    // Single arguments, including 0x80/0x7F boundaries
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = dir_val[i];
      check("dir_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("dir_lat1_valid", bus.out_valid, 0);
      tick();
      check("dir_lat2_valid", bus.out_valid, 1);
      check("dir_data", bus.out_data, dir_exp[i]);
      tick();
      check("dir_drained", bus.out_valid, 0);
    end

    // 100 back-to-back arguments
    nres = 0;
    for (int c = 0; c < 102; c++) begin
      if (bus.out_valid) begin
        if (exq.size() == 0) check("stream_extra", 1, 0);
        else check("stream_data", bus.out_data, exq.pop_front());
        nres++;
      end
      bus.in_valid = (c < 100);
      bus.in_data  = 8'(c * 13);
      if (c < 100) check("stream_in_ready", bus.in_ready, 1);
      if (bus.in_valid && bus.in_ready) exq.push_back(cls_of(bus.in_data));
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_results", nres, 100);
    check("stream_leftover", exq.size(), 0);

    // Backpressure: five offered, three accepted
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bp_val[acc];
      hs = bus.in_ready;
      tick();
      if (hs) acc++;
    end
    check("bp_accepted", acc, 3);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_head", bus.out_data, bp_exp[0]);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("bp_stall_data", bus.out_data, bp_exp[0]);
      check("bp_stall_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("bp_drain_valid", bus.out_valid, 1);
      check("bp_drain_data", bus.out_data, bp_exp[j]);
      tick();
    end
    check("bp_empty", bus.out_valid, 0);

    // Reset pulse with FIFO at TWO
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h05;
    tick();
    bus.in_data   = 8'hFF;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    check("mid_pre_valid", bus.out_valid, 1);
    check("mid_pre_ready", bus.in_ready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    #1;
    check("mid_rel_ready", bus.in_ready, 1);
    tick();
    check("mid_rel_ready_edge", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("mid_no_stale", bus.out_valid, 0);
      tick();
    end

`ifdef F4_STREAM_STATS_EN
    check("st_start_neg", cnt_neg, 0);
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hF0;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("st_neg_sat", cnt_neg, 15);
    check("st_pos_idle", cnt_pos, 0);
    check("st_zero_idle", cnt_zero, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    tick();
    bus.in_data  = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("st_pos_one", cnt_pos, 1);
    check("st_zero_one", cnt_zero, 1);
    check("st_neg_hold", cnt_neg, 15);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    tick();
    bus.in_valid = 1'b0;
    stats_clr    = 1'b1;
    tick();
    stats_clr    = 1'b0;
    check("st_clr_neg", cnt_neg, 0);
    check("st_clr_pos", cnt_pos, 0);
    check("st_clr_zero", cnt_zero, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f4_stream.md
F4_STREAM -- requirements
Module: f4_stream

Interface
REQ-001 The block SHALL be parameterised as follows, one per line:
- DATA_W, 8, argument and result width in bits (two's complement argument).
- CNT_W, 16, width of each statistics counter.
REQ-002 The block SHALL have the following ports, one per line:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, argument offered.
- in_ready, output, 1, argument accepted when in_valid && in_ready at a rising edge.
- in_data, input, DATA_W, signed argument.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result when out_valid && out_ready at a rising edge.
- out_data, output, DATA_W, class code, zero-extended.
- stats_clr, input, 1, synchronous clear of counters (only with F4_STREAM_STATS_EN).
- cnt_neg / cnt_pos / cnt_zero, output, CNT_W each, class counters (only with F4_STREAM_STATS_EN).
REQ-003 The clock SHALL be the only clock, and reset SHALL be asynchronous and active-low on reset_n.

Function
REQ-004 The class code SHALL be: 0 for in_data < 0 (signed), 1 for in_data > 0, and 2 for in_data == 0.
REQ-005 The datapath SHALL be a stage-1 register (s1_data, s1_valid) followed by a 3-entry output FIFO holding class codes.
REQ-006 On an input handshake, s1 SHALL load in_data and s1_valid SHALL go to 1; with no handshake, s1_valid SHALL go to 0.
REQ-007 When s1_valid=1, the class of s1_data SHALL be pushed into the FIFO at the same edge.
REQ-008 in_ready SHALL equal (fifo_count + s1_valid) < 3, with no combinational path from out_ready.
REQ-009 out_valid SHALL equal (fifo_count != 0); out_data SHALL be the FIFO head.
REQ-010 Latency SHALL be as follows:
- An argument accepted at edge k SHALL appear on out_data after edge k+1 when the FIFO was empty.
- Sustained throughput SHALL be one result per cycle while out_ready=1.
REQ-011 Occupancy states SHALL be EMPTY(0), ONE(1), TWO(2) and FULL(3).
- Push only: count+1.
- Pop only: count-1.
- Push and pop together: count unchanged.
- Push and pop together at EMPTY: not possible; the pushed entry becomes the head next cycle.
REQ-012 Read and write pointers SHALL wrap modulo 3, and the FIFO SHALL never overflow; REQ-008 guarantees this.
REQ-013 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Order SHALL be preserved, and no argument SHALL be dropped or duplicated.

Reset
REQ-015 While reset_n=0, outputs SHALL be held as follows:
- s1_valid=0, fifo_count=0 and both pointers=0.
- out_valid=0, out_data=0 and in_ready=0.
- All counters=0.
REQ-016 Assertion of reset_n mid-operation SHALL discard all in-flight data immediately, and in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-017 Macro F4_STREAM_STATS_EN defined SHALL enable the statistics feature:
- stats_clr, cnt_neg, cnt_pos and cnt_zero are present.
- Each FIFO push increments the matching counter, saturating at all-ones.
- stats_clr=1 clears all three counters at the edge and wins over a same-cycle increment.
REQ-018 Macro undefined SHALL remove those ports and counters, and datapath behaviour SHALL be identical.

Structure
REQ-019 Shared package f4_pkg SHALL hold the class-code constants CLS_NEG=0, CLS_POS=1, CLS_ZERO=2 and FIFO_DEPTH=3, used by this block and its consumers.
REQ-020 Classification SHALL be a combinational sub-module f4_classify (DATA_W in, DATA_W out) instantiated once on s1_data.

Verification
REQ-021 Single argument: in_data=0xFB (-5) with out_ready=1 -> out_valid after 2 edges with out_data=0; then in_data=0x07 -> 1; then in_data=0x00 -> 2.
REQ-022 Streaming: 100 back-to-back arguments with out_ready=1 -> in_ready stays 1 and results arrive in order, one per cycle.
REQ-023 Backpressure: out_ready=0 while feeding 5 arguments -> exactly 3 accepted, then in_ready=0; release out_ready -> 3 results in order with out_data stable while stalled.
REQ-024 Boundaries: in_data=0x80 -> 0 and in_data=0x7F -> 1; reset_n pulsed low with FIFO at TWO -> out_valid=0 immediately, in_ready=1 one cycle after release, and no stale results.
REQ-025 Stats (macro defined, CNT_W=4): 20 negative arguments -> cnt_neg=15 (saturated); stats_clr asserted on the same edge as a push -> all counters 0.
